// File: rtl/pmem_arb_pkg.sv
// Shared types and default widths for the physical-memory arbiter and its
// round-robin picker.
package pmem_arb_pkg;

    localparam int LINE_W_DEF = 256;
    localparam int ADDR_W_DEF = 32;
    localparam int CNT_W_DEF  = 32;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_SERVE_I,
        ARB_SERVE_D
    } arb_state_t;

    typedef enum logic {
        REQ_I,
        REQ_D
    } arb_req_t;

endpackage

// File: rtl/arb_rr_picker.sv
// Combinational two-way round-robin choice: on a tie the requester that was
// not granted last time wins.
module arb_rr_picker
    import pmem_arb_pkg::*;
(
    input  logic     i_req_i,
    input  logic     d_req_i,
    input  arb_req_t last_grant_i,
    output logic     grant_valid_o,
    output arb_req_t grant_o
);

    always_comb begin
        grant_valid_o = i_req_i | d_req_i;
        grant_o       = REQ_I;
        if (i_req_i && d_req_i) begin
            grant_o = (last_grant_i == REQ_I) ? REQ_D : REQ_I;
        end else if (d_req_i) begin
            grant_o = REQ_D;
        end
    end

endmodule

// File: rtl/pmem_arbiter.sv
// Shares the single physical memory port between the icache and dcache with
// round-robin grant, one transaction in flight, and saturating grant counters.
module pmem_arbiter
    import pmem_arb_pkg::*;
#(
    parameter int LINE_W = LINE_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output logic [CNT_W-1:0]  i_grant_count,
    output logic [CNT_W-1:0]  d_grant_count
);

    arb_state_t state_q, state_d;
    arb_req_t   last_grant_q, last_grant_d;
    logic [CNT_W-1:0] i_cnt_q, i_cnt_d;
    logic [CNT_W-1:0] d_cnt_q, d_cnt_d;

    logic     grant_valid;
    arb_req_t grant;

    arb_rr_picker u_picker (
        .i_req_i       (i_read),
        .d_req_i       (d_read | d_write),
        .last_grant_i  (last_grant_q),
        .grant_valid_o (grant_valid),
        .grant_o       (grant)
    );

    // last_grant resets to D so the icache wins the very first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= REQ_D;
            i_cnt_q      <= '0;
            d_cnt_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            i_cnt_q      <= i_cnt_d;
            d_cnt_q      <= d_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        i_cnt_d      = i_cnt_q;
        d_cnt_d      = d_cnt_q;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        i_resp       = 1'b0;
        i_rdata      = '0;
        d_resp       = 1'b0;
        d_rdata      = '0;

        unique case (state_q)
            ARB_IDLE: begin
                if (grant_valid) begin
                    state_d = (grant == REQ_I) ? ARB_SERVE_I : ARB_SERVE_D;
                end
            end
            ARB_SERVE_I: begin
                pmem_read    = 1'b1;
                pmem_address = i_address;
                if (pmem_resp) begin
                    i_resp       = 1'b1;
                    i_rdata      = pmem_rdata;
                    state_d      = ARB_IDLE;
                    last_grant_d = REQ_I;
                    if (i_cnt_q != '1) i_cnt_d = i_cnt_q + CNT_W'(1);
                end
            end
            // A write wins if the dcache illegally raises both strobes.
            ARB_SERVE_D: begin
                pmem_write   = d_write;
                pmem_read    = d_read & ~d_write;
                pmem_address = d_address;
                pmem_wdata   = d_wdata;
                if (pmem_resp) begin
                    d_resp       = 1'b1;
                    d_rdata      = pmem_rdata;
                    state_d      = ARB_IDLE;
                    last_grant_d = REQ_D;
                    if (d_cnt_q != '1) d_cnt_d = d_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign i_grant_count = i_cnt_q;
    assign d_grant_count = d_cnt_q;

endmodule
